// File: rtl/buffer_write_arbiter.sv
// buffer_write_arbiter: round-robin burst arbiter sharing one buffer write port among NUM_REQ producers (ports: clk, reset, req_valid/req_data/req_last/req_ready producers, buf_wr_en/buf_wr_data/buf_full buffer side, grant_id/busy status); define BUFFER_ARB_STATS_EN to add stat_sel/stat_count per-requester transfer counters
module buffer_write_arbiter #(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 8,
  parameter  int MAX_BURST  = 4,
  localparam int IW         = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1,
  localparam int CW         = $clog2(MAX_BURST + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          buf_wr_en,
  output logic [DATA_WIDTH-1:0]         buf_wr_data,
  input  logic                          buf_full,
  output logic [IW-1:0]                 grant_id,
`ifdef BUFFER_ARB_STATS_EN
  output logic                          busy,
  input  logic [IW-1:0]                 stat_sel,
  output logic [15:0]                   stat_count
`else
  output logic                          busy
`endif
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] grant_q, grant_d, last_q, last_d, win;
  logic [CW-1:0] beat_q, beat_d;
  logic found, xfer;
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && req_valid[(int'(last_q) + k) % NUM_REQ]) begin
        found = 1'b1;
        win   = IW'((int'(last_q) + k) % NUM_REQ);
      end
    end
  end
  assign xfer     = state_q == GRANT && req_valid[grant_q] && !buf_full && !reset;
  assign grant_id = grant_q;
  assign busy     = state_q == GRANT;
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    beat_d      = beat_q;
    req_ready   = '0;
    buf_wr_en   = xfer;
    buf_wr_data = '0;
    if (state_q == IDLE) begin
      if (found) begin
        state_d = GRANT;
        grant_d = win;
        last_d  = win;
        beat_d  = '0;
      end
    end else begin
      req_ready[grant_q] = !buf_full && !reset;
      buf_wr_data        = req_data[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
      beat_d             = beat_q + CW'(xfer);
      state_d = (!req_valid[grant_q] || (xfer && (req_last[grant_q] || beat_q == CW'(MAX_BURST - 1)))) ? IDLE : GRANT;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IW'(NUM_REQ - 1);
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
    end
  end
`ifdef BUFFER_ARB_STATS_EN
  logic [15:0] cnt_q [NUM_REQ];
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (reset) cnt_q[i] <= '0;
      else if (xfer && grant_q == IW'(i) && cnt_q[i] != 16'hFFFF) cnt_q[i] <= cnt_q[i] + 16'd1;
    end
  end
  assign stat_count = cnt_q[stat_sel];
`endif
endmodule

// File: doc/buffer_write_arbiter.md
Name: buffer_write_arbiter

Overview:
- Round-robin arbiter that shares the write port of one circular buffer among NUM_REQ producers.
- Each producer has a valid/ready/last stream interface. A winning producer keeps the grant for a burst of up to MAX_BURST beats.
- Sits directly in front of the buffer. Drives its wr_en/wr_data and watches its full flag.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_WIDTH, 8, beat width; must match the buffer's DATA_WIDTH.
- MAX_BURST, 4, maximum beats per grant (1..255).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester beat valid.
- req_data  input  NUM_REQ*DATA_WIDTH  requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_last  input  NUM_REQ  marks the final beat of a requester's burst.
- req_ready  output  NUM_REQ  beat accepted when valid & ready.
- buf_wr_en  output  1  to buffer wr_en.
- buf_wr_data  output  DATA_WIDTH  to buffer wr_data.
- buf_full  input  1  from buffer full.
- grant_id  output  $clog2(NUM_REQ)  current or last owner.
- busy  output  1  high while in GRANT.

Behaviour:
- Single clock, clk. Reset is synchronous and active-high: all state changes on the rising edge of clk while reset is high.
- Registered state:
  - FSM state: IDLE or GRANT.
  - grant_id.
  - beat_cnt, width $clog2(MAX_BURST+1).
  - last_ptr, the most recently granted index.
- Reset values:
  - state = IDLE, grant_id = 0, beat_cnt = 0, last_ptr = NUM_REQ-1, so requester 0 wins first.
  - Consequently req_ready = 0, buf_wr_en = 0, busy = 0, buf_wr_data = 0.
- IDLE state:
  - req_ready = 0, buf_wr_en = 0, buf_wr_data = 0.
  - If any req_valid is high, select the first valid index scanning last_ptr+1, last_ptr+2, … modulo NUM_REQ.
  - On the next edge: grant_id = winner, last_ptr = winner, beat_cnt = 0, state = GRANT.
  - Arbitration costs one bubble cycle: request seen in cycle N, ready may assert in cycle N+1.
- GRANT state, with g = grant_id (all combinational from registered state plus inputs):
  - req_ready[g] = !buf_full; every other req_ready bit = 0.
  - buf_wr_en = req_valid[g] & !buf_full.
  - buf_wr_data = req_data[g] (muxed regardless of valid).
  - A transfer is buf_wr_en = 1; beat_cnt increments by 1 on each transfer.
- Leave GRANT for IDLE on the edge where any of these holds:
  - a transfer with req_last[g] = 1;
  - a transfer that makes beat_cnt+1 == MAX_BURST;
  - req_valid[g] = 0, meaning the owner abandoned the grant with no transfer.
- Full stall:
  - While buf_full = 1: no transfer, beat_cnt holds, grant holds indefinitely (no timeout).
  - Data must not be dropped; the requester holds its beat until ready.
- Other boundaries:
  - Simultaneous new requests while in GRANT are ignored until back in IDLE.
  - A requester that deasserts valid in IDLE before being granted loses nothing.
  - The pointer wraps from NUM_REQ-1 to 0.
  - Reset mid-burst returns to IDLE next edge. Any beat presented in the reset cycle is not written (buf_wr_en forced 0 while reset high).
- No combinational path from buf_wr_en back to buf_full is created: the buffer's full comes from registers.

Optional Feature:
- Macro BUFFER_ARB_STATS_EN.
- When defined:
  - Adds ports stat_sel input $clog2(NUM_REQ) and stat_count output 16.
  - One 16-bit counter per requester increments on each transfer from that requester and saturates at 16'hFFFF.
  - All counters clear on reset.
  - stat_count = counter[stat_sel], combinational read.
- When undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
1. Sustained request: only req 0 valid for 6 beats with last=0, MAX_BURST=4, buffer never full.
   -> Beats 1-4 are written in 4 consecutive cycles, then one IDLE cycle, then req 0 is re-granted and beats 5-6 are written in order.
2. Round-robin order: all 4 requesters hold valid with req_last=1 every beat; data = 8'h10+i.
   -> grant_id sequence 0,1,2,3,0.
   -> buf_wr_data sequence 8'h10, 8'h11, 8'h12, 8'h13, 8'h10, each separated by one IDLE cycle.
3. Full stall: buf_full=1 for 3 cycles after beat 2 of req 1's burst.
   -> buf_wr_en=0 and req_ready[1]=0 for those 3 cycles; grant_id=1 and beat_cnt=2 held.
   -> Beat 3 is written the cycle full drops.
4. Reset mid-burst: assert reset for 1 cycle during GRANT to req 2 at beat_cnt=1.
   -> Next cycle is IDLE with all outputs 0.
   -> With reqs 0 and 3 then valid, req 0 is granted first.
5. Abandoned grant: req 1 drops valid after 1 beat while req 3 is valid.
   -> Arbiter returns to IDLE next edge; req 3 is granted the following edge; no spurious buf_wr_en.
6. Stats (BUFFER_ARB_STATS_EN defined): run scenario 2 for 8 granted beats.
   -> stat_count reads 2 for each stat_sel 0..3.
   -> After reset, all counters read 0.
